// File: rtl/dcache_port_arbiter.sv
// dcache_port_arbiter
// Shares the single data-cache port between MEM-stage load misses and the
// store-buffer drain. One transaction is in flight at a time. Loads normally
// win. Stores win when the buffer is full, when loads have starved the buffer
// for STARVE_LIMIT grants, or while a fence is draining the buffer.

module dcache_port_arbiter #(
    parameter int STARVE_LIMIT = 8   // 1..15
) (
    input  logic        clk,
    input  logic        reset,

    // MEM-stage load misses
    input  logic        ld_req,
    input  logic [31:0] ld_addr,
    output logic        ld_ack,
    output logic [31:0] ld_rdata,

    // Store-buffer head
    input  logic        sb_head_valid,
    input  logic [63:0] sb_head,
    input  logic        sb_full,
    output logic        sb_pop,

    // Fence handshake and pipeline stall
    input  logic        fence_req,
    output logic        fence_done,
    output logic        pipe_stall,

    // Data-cache port
    output logic        cache_req,
    output logic        cache_we,
    output logic [31:0] cache_addr,
    output logic [31:0] cache_wdata,
    input  logic        cache_ack,
    input  logic [31:0] cache_rdata
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        LOAD_WAIT  = 2'd1,
        STORE_WAIT = 2'd2
    } state_t;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    state_t     state;
    state_t     state_next;
    logic [3:0] starve_cnt;
    logic       fence_pending;

    logic       grant_store;
    logic       grant_load;
    logic       load_done;
    logic       fence_complete;

    // Grant arbitration in IDLE and completion tracking in the wait states.
    always_comb begin
        // NOTE: every signal gets a default before the case so that no path
        // leaves it unassigned; an unassigned path would infer a latch.
        state_next     = state;
        grant_store    = 1'b0;
        grant_load     = 1'b0;
        load_done      = 1'b0;
        fence_complete = 1'b0;

        case (state)
            IDLE: begin
                // The fence drain has finished once IDLE sees an empty buffer.
                fence_complete = fence_pending & ~sb_head_valid;

                // Priority chain: first matching rule wins.
                if (fence_pending && sb_head_valid) begin
                    grant_store = 1'b1;
                end else if (sb_head_valid && (sb_full || starve_cnt == STARVE_MAX)) begin
                    grant_store = 1'b1;
                end else if (ld_req && !ld_ack && !fence_pending) begin
                    // ld_req still high during its own ld_ack cycle is the
                    // load just served, so it must not be granted again.
                    grant_load = 1'b1;
                end else if (sb_head_valid) begin
                    grant_store = 1'b1;
                end

                if (grant_store) begin
                    state_next = STORE_WAIT;
                end else if (grant_load) begin
                    state_next = LOAD_WAIT;
                end
            end

            LOAD_WAIT: begin
                if (cache_ack) begin
                    load_done  = 1'b1;
                    state_next = IDLE;
                end
            end

            STORE_WAIT: begin
                if (cache_ack) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The head leaves the store buffer on the grant edge itself; nothing is
    // popped while reset is held.
    assign sb_pop     = grant_store & ~reset;
    assign pipe_stall = (ld_req & ~ld_ack) | fence_pending;

    // FSM state register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state always uses non-blocking assignment so every
        // register samples pre-edge values regardless of block ordering.
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Registered cache-port and load-response outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            cache_req   <= 1'b0;
            cache_we    <= 1'b0;
            cache_addr  <= '0;
            cache_wdata <= '0;
            ld_ack      <= 1'b0;
            ld_rdata    <= '0;
            fence_done  <= 1'b0;
        end else begin
            cache_req  <= (state_next != IDLE);
            cache_we   <= (state_next == STORE_WAIT);
            ld_ack     <= load_done;
            fence_done <= fence_complete;

            // Address and data are held for the whole transaction.
            if (grant_store) begin
                cache_addr  <= sb_head[63:32];
                cache_wdata <= sb_head[31:0];
            end else if (grant_load) begin
                cache_addr  <= ld_addr;
            end

            if (load_done) begin
                ld_rdata <= cache_rdata;
            end
        end
    end

    // Fence-pending flag and load-versus-store starvation counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            fence_pending <= 1'b0;
            starve_cnt    <= '0;
        end else begin
            // Completion is only possible while pending, so a repeated
            // fence_req during a drain cannot extend it.
            if (fence_complete) begin
                fence_pending <= 1'b0;
            end else if (fence_req) begin
                fence_pending <= 1'b1;
            end

            // Counts load grants that bypassed a waiting store; saturates.
            if (grant_store) begin
                starve_cnt <= '0;
            end else if (grant_load && sb_head_valid && starve_cnt < STARVE_MAX) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Self-checking bench for dcache_port_arbiter (STARVE_LIMIT = 2).
// A cycle-by-cycle vector table covers load, drain, full priority,
// starvation and fence drain; hand-written sequences cover fence timing on
// an empty buffer and reset in the middle of a load.

module tb_dcache_port_arbiter;

    logic        clk;
    logic        reset;
    logic        ld_req;
    logic [31:0] ld_addr;
    logic        ld_ack;
    logic [31:0] ld_rdata;
    logic        sb_head_valid;
    logic [63:0] sb_head;
    logic        sb_full;
    logic        sb_pop;
    logic        fence_req;
    logic        fence_done;
    logic        pipe_stall;
    logic        cache_req;
    logic        cache_we;
    logic [31:0] cache_addr;
    logic [31:0] cache_wdata;
    logic        cache_ack;
    logic [31:0] cache_rdata;

    int n_checks = 0;
    int n_pass   = 0;

    dcache_port_arbiter #(.STARVE_LIMIT(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .ld_req        (ld_req),
        .ld_addr       (ld_addr),
        .ld_ack        (ld_ack),
        .ld_rdata      (ld_rdata),
        .sb_head_valid (sb_head_valid),
        .sb_head       (sb_head),
        .sb_full       (sb_full),
        .sb_pop        (sb_pop),
        .fence_req     (fence_req),
        .fence_done    (fence_done),
        .pipe_stall    (pipe_stall),
        .cache_req     (cache_req),
        .cache_we      (cache_we),
        .cache_addr    (cache_addr),
        .cache_wdata   (cache_wdata),
        .cache_ack     (cache_ack),
        .cache_rdata   (cache_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock cycle: inputs driven after the falling edge, outputs
    // (registered ones from the previous edge, combinational ones from the
    // current inputs) compared before the next rising edge.
    typedef struct {
        logic        chk;
        logic        rst;
        logic        ld;
        logic [31:0] la;
        logic        sbv;
        logic [63:0] sh;
        logic        full;
        logic        fen;
        logic        ack;
        logic [31:0] rd;
        logic        e_req;
        logic        e_we;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic        e_ack;
        logic [31:0] e_rdata;
        logic        e_pop;
        logic        e_fdone;
        logic        e_stall;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic rst, input logic ld, input logic [31:0] la, input logic sbv,
        input logic [63:0] sh, input logic full, input logic fen, input logic ack,
        input logic [31:0] rd,
        input logic e_req, input logic e_we, input logic [31:0] e_addr,
        input logic [31:0] e_wdata, input logic e_ack, input logic [31:0] e_rdata,
        input logic e_pop, input logic e_fdone, input logic e_stall);
        vec_t v;
        v.chk = !rst;  v.rst = rst;   v.ld = ld;     v.la = la;
        v.sbv = sbv;   v.sh = sh;     v.full = full; v.fen = fen;
        v.ack = ack;   v.rd = rd;
        v.e_req = e_req;     v.e_we = e_we;       v.e_addr = e_addr;
        v.e_wdata = e_wdata; v.e_ack = e_ack;     v.e_rdata = e_rdata;
        v.e_pop = e_pop;     v.e_fdone = e_fdone; v.e_stall = e_stall;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic drive_idle();
        reset = 1'b0; ld_req = 1'b0; ld_addr = '0; sb_head_valid = 1'b0;
        sb_head = '0; sb_full = 1'b0; fence_req = 1'b0; cache_ack = 1'b0;
        cache_rdata = '0;
    endtask

    task automatic apply(input vec_t v);
        reset = v.rst; ld_req = v.ld; ld_addr = v.la; sb_head_valid = v.sbv;
        sb_head = v.sh; sb_full = v.full; fence_req = v.fen;
        cache_ack = v.ack; cache_rdata = v.rd;
    endtask

    task automatic compare(input int i, input vec_t v);
        check($sformatf("v%0d cache_req", i),   64'(cache_req),   64'(v.e_req));
        check($sformatf("v%0d cache_we", i),    64'(cache_we),    64'(v.e_we));
        check($sformatf("v%0d cache_addr", i),  64'(cache_addr),  64'(v.e_addr));
        check($sformatf("v%0d cache_wdata", i), 64'(cache_wdata), 64'(v.e_wdata));
        check($sformatf("v%0d ld_ack", i),      64'(ld_ack),      64'(v.e_ack));
        check($sformatf("v%0d ld_rdata", i),    64'(ld_rdata),    64'(v.e_rdata));
        check($sformatf("v%0d sb_pop", i),      64'(sb_pop),      64'(v.e_pop));
        check($sformatf("v%0d fence_done", i),  64'(fence_done),  64'(v.e_fdone));
        check($sformatf("v%0d pipe_stall", i),  64'(pipe_stall),  64'(v.e_stall));
    endtask

    // Hard time limit so the run always ends on its own.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] h40, h80, hc0, hd0, e1, e2, e3;
        int  n;
        logic seen_ack;

        h40 = {32'h40,   32'h1234};
        h80 = {32'h80,   32'hAAAA};
        hc0 = {32'hC0,   32'h5555};
        hd0 = {32'hD0,   32'h6666};
        e1  = {32'h1000, 32'hA1};
        e2  = {32'h1004, 32'hA2};
        e3  = {32'h1008, 32'hA3};

        drive_idle();
        reset = 1'b1;

        //              rst ld la         sbv sh   full fen ack rd           | req we addr      wdata   ack rdata         pop fd st
        // Reset, then reset values
        vecs.push_back(mk(1, 0, 32'h0,     0, 64'h0, 0, 0, 0, 32'h0,          0, 0, 32'h0,    32'h0,    0, 32'h0,        0, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,     0, 64'h0, 0, 0, 0, 32'h0,          0, 0, 32'h0,    32'h0,    0, 32'h0,        0, 0, 0));
        // Basic load at 0x100, cache_ack three cycles after cache_req rises
        vecs.push_back(mk(0, 1, 32'h100,   0, 64'h0, 0, 0, 0, 32'h0,          0, 0, 32'h0,    32'h0,    0, 32'h0,        0, 0, 1));
        vecs.push_back(mk(0, 1, 32'h100,   0, 64'h0, 0, 0, 0, 32'h0,          1, 0, 32'h100,  32'h0,    0, 32'h0,        0, 0, 1));
        vecs.push_back(mk(0, 1, 32'h100,   0, 64'h0, 0, 0, 0, 32'h0,          1, 0, 32'h100,  32'h0,    0, 32'h0,        0, 0, 1));
        vecs.push_back(mk(0, 1, 32'h100,   0, 64'h0, 0, 0, 0, 32'h0,          1, 0, 32'h100,  32'h0,    0, 32'h0,        0, 0, 1));
        vecs.push_back(mk(0, 1, 32'h100,   0, 64'h0, 0, 0, 1, 32'hDEADBEEF,   1, 0, 32'h100,  32'h0,    0, 32'h0,        0, 0, 1));
        vecs.push_back(mk(0, 1, 32'h100,   0, 64'h0, 0, 0, 0, 32'h0,          0, 0, 32'h100,  32'h0,    1, 32'hDEADBEEF, 0, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,     0, 64'h0, 0, 0, 0, 32'h0,          0, 0, 32'h100,  32'h0,    0, 32'hDEADBEEF, 0, 0, 0));
        // Drain when idle; a cache_ack arriving in IDLE is ignored
        vecs.push_back(mk(0, 0, 32'h0,     1, h40,   0, 0, 0, 32'h0,          0, 0, 32'h100,  32'h0,    0, 32'hDEADBEEF, 1, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,     0, 64'h0, 0, 0, 0, 32'h0,          1, 1, 32'h40,   32'h1234, 0, 32'hDEADBEEF, 0, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,     0, 64'h0, 0, 0, 1, 32'h0,          1, 1, 32'h40,   32'h1234, 0, 32'hDEADBEEF, 0, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,     0, 64'h0, 0, 0, 1, 32'h0,          0, 0, 32'h40,   32'h1234, 0, 32'hDEADBEEF, 0, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,     0, 64'h0, 0, 0, 0, 32'h0,          0, 0, 32'h40,   32'h1234, 0, 32'hDEADBEEF, 0, 0, 0));
        // Full priority: store first, load granted after the store's ack
        vecs.push_back(mk(0, 1, 32'h200,   1, h80,   1, 0, 0, 32'h0,          0, 0, 32'h40,   32'h1234, 0, 32'hDEADBEEF, 1, 0, 1));
        vecs.push_back(mk(0, 1, 32'h200,   0, 64'h0, 0, 0, 0, 32'h0,          1, 1, 32'h80,   32'hAAAA, 0, 32'hDEADBEEF, 0, 0, 1));
        vecs.push_back(mk(0, 1, 32'h200,   0, 64'h0, 0, 0, 1, 32'h0,          1, 1, 32'h80,   32'hAAAA, 0, 32'hDEADBEEF, 0, 0, 1));
        vecs.push_back(mk(0, 1, 32'h200,   0, 64'h0, 0, 0, 0, 32'h0,          0, 0, 32'h80,   32'hAAAA, 0, 32'hDEADBEEF, 0, 0, 1));
        vecs.push_back(mk(0, 1, 32'h200,   0, 64'h0, 0, 0, 1, 32'h11112222,   1, 0, 32'h200,  32'hAAAA, 0, 32'hDEADBEEF, 0, 0, 1));
        vecs.push_back(mk(0, 1, 32'h200,   0, 64'h0, 0, 0, 0, 32'h0,          0, 0, 32'h200,  32'hAAAA, 1, 32'h11112222,   0, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,     0, 64'h0, 0, 0, 0, 32'h0,          0, 0, 32'h200,  32'hAAAA, 0, 32'h11112222,   0, 0, 0));
        // Starvation (limit 2). The head is hidden during ld_ack cycles so
        // the opportunistic drain cannot fire between the two loads.
        vecs.push_back(mk(0, 1, 32'h300,   1, hc0,   0, 0, 0, 32'h0,          0, 0, 32'h200,  32'hAAAA, 0, 32'h11112222,   0, 0, 1));
        vecs.push_back(mk(0, 1, 32'h300,   1, hc0,   0, 0, 1, 32'h33,         1, 0, 32'h300,  32'hAAAA, 0, 32'h11112222,   0, 0, 1));
        vecs.push_back(mk(0, 0, 32'h0,     0, 64'h0, 0, 0, 0, 32'h0,          0, 0, 32'h300,  32'hAAAA, 1, 32'h33,         0, 0, 0));
        vecs.push_back(mk(0, 1, 32'h304,   1, hc0,   0, 0, 0, 32'h0,          0, 0, 32'h300,  32'hAAAA, 0, 32'h33,         0, 0, 1));
        vecs.push_back(mk(0, 1, 32'h304,   1, hc0,   0, 0, 1, 32'h44,         1, 0, 32'h304,  32'hAAAA, 0, 32'h33,         0, 0, 1));
        vecs.push_back(mk(0, 0, 32'h0,     0, 64'h0, 0, 0, 0, 32'h0,          0, 0, 32'h304,  32'hAAAA, 1, 32'h44,         0, 0, 0));
        vecs.push_back(mk(0, 1, 32'h308,   1, hc0,   0, 0, 0, 32'h0,          0, 0, 32'h304,  32'hAAAA, 0, 32'h44,         1, 0, 1));
        vecs.push_back(mk(0, 1, 32'h308,   0, 64'h0, 0, 0, 1, 32'h0,          1, 1, 32'hC0,   32'h5555, 0, 32'h44,         0, 0, 1));
        // starve_cnt is back to 0, so the load wins over the waiting store
        vecs.push_back(mk(0, 1, 32'h308,   1, hd0,   0, 0, 0, 32'h0,          0, 0, 32'hC0,   32'h5555, 0, 32'h44,         0, 0, 1));
        vecs.push_back(mk(0, 1, 32'h308,   1, hd0,   0, 0, 1, 32'h55,         1, 0, 32'h308,  32'h5555, 0, 32'h44,         0, 0, 1));
        vecs.push_back(mk(0, 0, 32'h0,     1, hd0,   0, 0, 0, 32'h0,          0, 0, 32'h308,  32'h5555, 1, 32'h55,         1, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,     0, 64'h0, 0, 0, 1, 32'h0,          1, 1, 32'hD0,   32'h6666, 0, 32'h55,         0, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,     0, 64'h0, 0, 0, 0, 32'h0,          0, 0, 32'hD0,   32'h6666, 0, 32'h55,         0, 0, 0));
        // Fence with three buffered entries and a pending load
        vecs.push_back(mk(0, 0, 32'h0,     1, e1,    0, 1, 0, 32'h0,          0, 0, 32'hD0,   32'h6666, 0, 32'h55,         1, 0, 0));
        vecs.push_back(mk(0, 1, 32'h400,   1, e2,    0, 0, 0, 32'h0,          1, 1, 32'h1000, 32'hA1,   0, 32'h55,         0, 0, 1));
        vecs.push_back(mk(0, 1, 32'h400,   1, e2,    0, 0, 1, 32'h0,          1, 1, 32'h1000, 32'hA1,   0, 32'h55,         0, 0, 1));
        vecs.push_back(mk(0, 1, 32'h400,   1, e2,    0, 1, 0, 32'h0,          0, 0, 32'h1000, 32'hA1,   0, 32'h55,         1, 0, 1));
        vecs.push_back(mk(0, 1, 32'h400,   1, e3,    0, 0, 1, 32'h0,          1, 1, 32'h1004, 32'hA2,   0, 32'h55,         0, 0, 1));
        vecs.push_back(mk(0, 1, 32'h400,   1, e3,    0, 0, 0, 32'h0,          0, 0, 32'h1004, 32'hA2,   0, 32'h55,         1, 0, 1));
        vecs.push_back(mk(0, 1, 32'h400,   0, 64'h0, 0, 0, 1, 32'h0,          1, 1, 32'h1008, 32'hA3,   0, 32'h55,         0, 0, 1));
        vecs.push_back(mk(0, 1, 32'h400,   0, 64'h0, 0, 0, 0, 32'h0,          0, 0, 32'h1008, 32'hA3,   0, 32'h55,         0, 0, 1));
        vecs.push_back(mk(0, 1, 32'h400,   0, 64'h0, 0, 0, 0, 32'h0,          0, 0, 32'h1008, 32'hA3,   0, 32'h55,         0, 1, 1));
        vecs.push_back(mk(0, 1, 32'h400,   0, 64'h0, 0, 0, 1, 32'h66,         1, 0, 32'h400,  32'hA3,   0, 32'h55,         0, 0, 1));
        vecs.push_back(mk(0, 0, 32'h0,     0, 64'h0, 0, 0, 0, 32'h0,          0, 0, 32'h400,  32'hA3,   1, 32'h66,         0, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,     0, 64'h0, 0, 0, 0, 32'h0,          0, 0, 32'h400,  32'hA3,   0, 32'h66,         0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            apply(vecs[i]);
            #1;
            if (vecs[i].chk) compare(i, vecs[i]);
        end

        // Fence on an empty buffer: fence_done two cycles after fence_req.
        @(negedge clk);
        drive_idle();
        fence_req = 1'b1;
        #1;
        check("fe_done_t0",  64'(fence_done), 64'd0);
        check("fe_stall_t0", 64'(pipe_stall), 64'd0);
        @(negedge clk);
        fence_req = 1'b0;
        #1;
        check("fe_done_t1",  64'(fence_done), 64'd0);
        check("fe_stall_t1", 64'(pipe_stall), 64'd1);
        @(negedge clk);
        #1;
        check("fe_done_t2",  64'(fence_done), 64'd1);
        check("fe_stall_t2", 64'(pipe_stall), 64'd0);
        @(negedge clk);
        #1;
        check("fe_done_t3",  64'(fence_done), 64'd0);

        // Reset while in LOAD_WAIT abandons the load.
        @(negedge clk);
        ld_req  = 1'b1;
        ld_addr = 32'h500;
        @(negedge clk);
        #1;
        check("rs_req_before", 64'(cache_req),  64'd1);
        check("rs_addr_before", 64'(cache_addr), 64'h500);
        reset  = 1'b1;
        ld_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rs_req_after",   64'(cache_req), 64'd0);
        check("rs_addr_after",  64'(cache_addr), 64'd0);
        check("rs_rdata_after", 64'(ld_rdata),  64'd0);
        // A stale cache_ack for the abandoned load must not produce ld_ack.
        cache_ack   = 1'b1;
        cache_rdata = 32'hBAD0BAD0;
        seen_ack    = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            cache_ack = 1'b0;
            #1;
            if (ld_ack) seen_ack = 1'b1;
        end
        check("rs_no_ld_ack", 64'(seen_ack), 64'd0);

        // A fresh load after reset completes with minimum latency.
        @(negedge clk);
        ld_req  = 1'b1;
        ld_addr = 32'h600;
        #1;
        n = 0;
        while (!cache_req && n < 10) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("nl_req_seen", 64'(cache_req),  64'd1);
        check("nl_req_lat",  64'(n),          64'd1);
        check("nl_addr",     64'(cache_addr), 64'h600);
        check("nl_we",       64'(cache_we),   64'd0);
        cache_ack   = 1'b1;
        cache_rdata = 32'hCAFEF00D;
        @(negedge clk);
        cache_ack = 1'b0;
        #1;
        check("nl_ld_ack",   64'(ld_ack),   64'd1);
        check("nl_ld_rdata", 64'(ld_rdata), 64'hCAFEF00D);
        check("nl_cache_req_drop", 64'(cache_req), 64'd0);
        ld_req = 1'b0;
        @(negedge clk);
        #1;
        check("nl_ld_ack_pulse", 64'(ld_ack), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
